// File: rtl/rpeak_pkg.sv
// Shared state encoding and default configuration for the R-peak detector controller.
package rpeak_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        QRS   = 2'd2,
        REFR  = 2'd3
    } state_t;

    localparam int DEF_CLK_DIV = 1000;
    localparam int DEF_MIN_QRS = 2;
    localparam int DEF_REFRACT = 50;
    localparam int DEF_RR_W    = 12;

    // Saturating increment used by the RR interval counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
        return (value >= max) ? max : value + 32'd1;
    endfunction

endpackage

// File: rtl/sample_tick.sv
// ECG sample-rate divider: one-cycle tick every CLK_DIV enabled clocks, held at zero while disabled.
module sample_tick
    import rpeak_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = en && (count == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rpeak_ctrl.sv
// R-peak detector control: sample divider, QRS qualification FSM, RR interval counter and
// valid/ready output stage. Defining RR_AVG_EN adds rr_avg, the mean of the last 8 RR values.
module rpeak_ctrl
    import rpeak_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int MIN_QRS = DEF_MIN_QRS,
    parameter int REFRACT = DEF_REFRACT,
    parameter int RR_W    = DEF_RR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            slope_in,
    output logic            sample_en,
    output logic            beat,
    output logic [RR_W-1:0] rr_data,
    output logic            rr_valid,
    input  logic            rr_ready,
    output logic            overrun,
`ifdef RR_AVG_EN
    output logic [RR_W-1:0] rr_avg,
`endif
    output logic [1:0]      state
);

    localparam int QW = $clog2(MIN_QRS + 1);
    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
    localparam logic [RR_W-1:0] RR_MAX = {RR_W{1'b1}};

    // rr_data/rr_valid use valid/ready semantics: a value is transferred on any cycle
    // where rr_valid and rr_ready are both high; rr_valid never depends on rr_ready
    // combinationally, and a new value may replace an unaccepted one (flagged by overrun).

    state_t          state_q, state_d;
    logic [QW-1:0]   qrs_cnt, qrs_d;
    logic [RW-1:0]   ref_cnt, ref_d;
    logic [RR_W-1:0] rr_cnt, rr_cnt_inc;
    logic            qualify;
    logic            rr_load;
    logic            first_beat;
    logic            beat_q;
    logic [RR_W-1:0] rr_data_q;
    logic            rr_valid_q;
    logic            overrun_q;

    sample_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (sample_en)
    );

    assign state    = state_q;
    assign beat     = beat_q;
    assign rr_data  = rr_data_q;
    assign rr_valid = rr_valid_q;
    assign overrun  = overrun_q;

    assign rr_cnt_inc = RR_W'(sat_inc(32'(rr_cnt), 32'(RR_MAX)));
    assign rr_load    = qualify && !first_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            qrs_cnt <= '0;
            ref_cnt <= '0;
        end else begin
            state_q <= state_d;
            qrs_cnt <= qrs_d;
            ref_cnt <= ref_d;
        end
    end

    // Apart from leaving IDLE and the en=0 abort, moves happen only on sample strobes.
    always_comb begin
        state_d = state_q;
        qrs_d   = qrs_cnt;
        ref_d   = ref_cnt;
        qualify = 1'b0;
        if (!en) begin
            state_d = IDLE;
            qrs_d   = '0;
            ref_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (sample_en && slope_in) begin
                        if (MIN_QRS == 1) begin
                            state_d = REFR;
                            ref_d   = '0;
                            qualify = 1'b1;
                        end else begin
                            state_d = QRS;
                            qrs_d   = QW'(1);
                        end
                    end
                end
                QRS: begin
                    if (sample_en) begin
                        if (!slope_in) begin
                            state_d = ARMED;
                        end else if (int'(qrs_cnt) + 1 == MIN_QRS) begin
                            state_d = REFR;
                            ref_d   = '0;
                            qualify = 1'b1;
                        end else begin
                            qrs_d = qrs_cnt + 1'b1;
                        end
                    end
                end
                REFR: begin
                    if (sample_en) begin
                        if (int'(ref_cnt) == REFRACT - 1) begin
                            state_d = ARMED;
                        end else begin
                            ref_d = ref_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The loaded interval includes the qualifying sample itself, hence rr_cnt_inc.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= 1'b0;
            first_beat <= 1'b1;
            rr_cnt     <= '0;
            rr_data_q  <= '0;
            rr_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            beat_q    <= qualify;
            overrun_q <= 1'b0;
            if (!en) begin
                first_beat <= 1'b1;
                rr_cnt     <= '0;
            end else begin
                if (beat_q) begin
                    rr_cnt <= sample_en ? RR_W'(1) : '0;
                end else if (sample_en && state_q != IDLE) begin
                    rr_cnt <= rr_cnt_inc;
                end
                if (qualify) begin
                    first_beat <= 1'b0;
                end
            end
            if (rr_load) begin
                rr_data_q  <= rr_cnt_inc;
                rr_valid_q <= 1'b1;
                overrun_q  <= rr_valid_q && !rr_ready;
            end else if (rr_valid_q && rr_ready) begin
                rr_valid_q <= 1'b0;
            end
        end
    end

`ifdef RR_AVG_EN
    logic [RR_W-1:0] hist [8];
    logic [RR_W+2:0] sum;

    // Running sum: add the newest interval, drop the one falling out of the window.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            for (int i = 0; i < 8; i++) begin
                hist[i] <= '0;
            end
            sum <= '0;
        end else if (rr_load) begin
            sum     <= sum - {3'b000, hist[7]} + {3'b000, rr_cnt_inc};
            hist[0] <= rr_cnt_inc;
            for (int i = 1; i < 8; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    assign rr_avg = sum[RR_W+2:3];
`endif

endmodule

// File: tb/tb_rpeak_ctrl.sv
// Directed bench for rpeak_ctrl with CLK_DIV=4, MIN_QRS=2, REFRACT=5, RR_W=12.
module tb_rpeak_ctrl;

    localparam int RR_W = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            slope_in = 1'b0;
    logic            rr_ready = 1'b0;
    logic            sample_en;
    logic            beat;
    logic [RR_W-1:0] rr_data;
    logic            rr_valid;
    logic            overrun;
    logic [1:0]      state;
`ifdef RR_AVG_EN
    logic [RR_W-1:0] rr_avg;
`endif

    int vectors  = 0;
    int errors   = 0;
    int beat_cnt = 0;
    int ovr_cnt  = 0;

    always #5 clk = ~clk;

    rpeak_ctrl #(
        .CLK_DIV (4),
        .MIN_QRS (2),
        .REFRACT (5),
        .RR_W    (RR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .slope_in  (slope_in),
        .sample_en (sample_en),
        .beat      (beat),
        .rr_data   (rr_data),
        .rr_valid  (rr_valid),
        .rr_ready  (rr_ready),
        .overrun   (overrun),
`ifdef RR_AVG_EN
        .rr_avg    (rr_avg),
`endif
        .state     (state)
    );

    always @(negedge clk) begin
        if (beat) beat_cnt++;
        if (overrun) ovr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; slope_in = 1'b0; rr_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    // Waits for the next sample strobe, presents slope/ready during it, ends one cycle later.
    task automatic do_sample(input logic s, input logic rdy);
        int n = 0;
        while (!sample_en && n < 16) begin
            step();
            n++;
        end
        if (!sample_en) begin
            vectors++; errors++;
            $display("FAIL sample_wait got sample_en=%0b exp=1 within 16 cycles", sample_en);
        end
        slope_in = s;
        rr_ready = rdy;
        step();
        slope_in = 1'b0;
        rr_ready = 1'b0;
    endtask

    task automatic make_beat(input logic rdy);
        do_sample(1'b1, 1'b0);
        do_sample(1'b1, rdy);
    endtask

    // Qualifying sample lands n samples after the previous qualifying sample.
    task automatic gap_beat(input int n, input logic rdy);
        for (int i = 0; i < n - 2; i++) do_sample(1'b0, 1'b0);
        make_beat(rdy);
    endtask

    task automatic test_reset();
        logic exp_se;
        rst = 1'b1; en = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        vectors++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        vectors++; if (sample_en !== 1'b0) begin errors++; $display("FAIL reset_sample_en got=%0b exp=0", sample_en); end
        vectors++; if (beat !== 1'b0) begin errors++; $display("FAIL reset_beat got=%0b exp=0", beat); end
        vectors++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL reset_rr_valid got=%0b exp=0", rr_valid); end
        vectors++; if (rr_data !== 12'd0) begin errors++; $display("FAIL reset_rr_data got=%0d exp=0", rr_data); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_se = (c % 4 == 3);
            vectors++; if (sample_en !== exp_se) begin errors++; $display("FAIL tick_c%0d got=%0b exp=%0b", c, sample_en, exp_se); end
            vectors++; if (state !== 2'd1) begin errors++; $display("FAIL armed_c%0d got=%0d exp=1", c, state); end
            vectors++; if ({beat, rr_valid, overrun} !== 3'b000) begin errors++; $display("FAIL quiet_c%0d got=%b exp=000", c, {beat, rr_valid, overrun}); end
        end
    endtask

    task automatic test_glitch();
        int b0 = beat_cnt;
        do_sample(1'b1, 1'b0);
        vectors++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_qrs got=%0d exp=2", state); end
        do_sample(1'b0, 1'b0);
        vectors++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_rearm got=%0d exp=1", state); end
        vectors++; if (beat_cnt !== b0) begin errors++; $display("FAIL glitch_nobeat got=%0d exp=%0d", beat_cnt, b0); end
    endtask

    task automatic test_refractory();
        int b0 = beat_cnt;
        logic [1:0] exp_st;
        make_beat(1'b0);
        vectors++; if (beat !== 1'b1) begin errors++; $display("FAIL refr_beat got=%0b exp=1", beat); end
        vectors++; if (state !== 2'd3) begin errors++; $display("FAIL refr_enter got=%0d exp=3", state); end
        vectors++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL first_beat_valid got=%0b exp=0", rr_valid); end
        for (int i = 1; i <= 5; i++) begin
            do_sample(1'b1, 1'b0);
            exp_st = (i < 5) ? 2'd3 : 2'd1;
            vectors++; if (state !== exp_st) begin errors++; $display("FAIL refr_s%0d got=%0d exp=%0d", i, state, exp_st); end
        end
        vectors++; if (beat_cnt !== b0 + 1) begin errors++; $display("FAIL refr_beats got=%0d exp=%0d", beat_cnt, b0 + 1); end
        do_sample(1'b1, 1'b0);
        vectors++; if (state !== 2'd2) begin errors++; $display("FAIL refr_rearm_qrs got=%0d exp=2", state); end
        do_sample(1'b0, 1'b0);
    endtask

    task automatic test_rr_interval();
        do_reset();
        make_beat(1'b0);
        vectors++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL rr_first_valid got=%0b exp=0", rr_valid); end
        gap_beat(100, 1'b0);
        vectors++; if (beat !== 1'b1) begin errors++; $display("FAIL rr_beat got=%0b exp=1", beat); end
        vectors++; if (rr_valid !== 1'b1) begin errors++; $display("FAIL rr_valid got=%0b exp=1", rr_valid); end
        vectors++; if (rr_data !== 12'd100) begin errors++; $display("FAIL rr_data got=%0d exp=100", rr_data); end
        step();
        vectors++; if (beat !== 1'b0) begin errors++; $display("FAIL beat_width got=%0b exp=0", beat); end
        step(); step(); step();
        vectors++; if (rr_valid !== 1'b1 || rr_data !== 12'd100) begin errors++; $display("FAIL rr_hold got=%0b/%0d exp=1/100", rr_valid, rr_data); end
        rr_ready = 1'b1;
        #1;
        vectors++; if (rr_valid !== 1'b1) begin errors++; $display("FAIL rr_no_comb got=%0b exp=1", rr_valid); end
        step();
        rr_ready = 1'b0;
        vectors++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL rr_accept got=%0b exp=0", rr_valid); end
    endtask

    task automatic test_overrun();
        int o0;
        do_reset();
        make_beat(1'b0);
        o0 = ovr_cnt;
        gap_beat(20, 1'b0);
        vectors++; if (rr_data !== 12'd20 || rr_valid !== 1'b1) begin errors++; $display("FAIL ovr_first got=%0d/%0b exp=20/1", rr_data, rr_valid); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%0b exp=0", overrun); end
        gap_beat(30, 1'b0);
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got=%0b exp=1", overrun); end
        vectors++; if (rr_data !== 12'd30 || rr_valid !== 1'b1) begin errors++; $display("FAIL ovr_latest got=%0d/%0b exp=30/1", rr_data, rr_valid); end
        step();
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_width got=%0b exp=0", overrun); end
        vectors++; if (ovr_cnt !== o0 + 1) begin errors++; $display("FAIL ovr_count got=%0d exp=%0d", ovr_cnt, o0 + 1); end
    endtask

    task automatic test_back_to_back();
        int o0;
        do_reset();
        make_beat(1'b0);
        gap_beat(20, 1'b0);
        vectors++; if (rr_data !== 12'd20 || rr_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got=%0d/%0b exp=20/1", rr_data, rr_valid); end
        o0 = ovr_cnt;
        gap_beat(25, 1'b1);
        vectors++; if (rr_valid !== 1'b1 || rr_data !== 12'd25) begin errors++; $display("FAIL b2b_load got=%0b/%0d exp=1/25", rr_valid, rr_data); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
        step();
        vectors++; if (rr_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold got=%0b exp=1", rr_valid); end
        vectors++; if (ovr_cnt !== o0) begin errors++; $display("FAIL b2b_ovr_count got=%0d exp=%0d", ovr_cnt, o0); end
    endtask

    task automatic test_en_drop();
        for (int i = 0; i < 5; i++) do_sample(1'b0, 1'b0);
        do_sample(1'b1, 1'b0);
        vectors++; if (state !== 2'd2) begin errors++; $display("FAIL en_pre_qrs got=%0d exp=2", state); end
        en = 1'b0;
        step();
        vectors++; if (state !== 2'd0) begin errors++; $display("FAIL en_idle got=%0d exp=0", state); end
        vectors++; if (sample_en !== 1'b0) begin errors++; $display("FAIL en_tick got=%0b exp=0", sample_en); end
        vectors++; if (rr_valid !== 1'b1 || rr_data !== 12'd25) begin errors++; $display("FAIL en_retain got=%0b/%0d exp=1/25", rr_valid, rr_data); end
        rr_ready = 1'b1;
        step();
        rr_ready = 1'b0;
        vectors++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL en_drain got=%0b exp=0", rr_valid); end
        en = 1'b1;
        step();
        vectors++; if (state !== 2'd1) begin errors++; $display("FAIL en_rearm got=%0d exp=1", state); end
        make_beat(1'b0);
        vectors++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL en_first_beat got=%0b exp=0", rr_valid); end
        gap_beat(10, 1'b0);
        vectors++; if (rr_data !== 12'd10 || rr_valid !== 1'b1) begin errors++; $display("FAIL en_rr got=%0d/%0b exp=10/1", rr_data, rr_valid); end
    endtask

    task automatic test_rst_priority();
        do_sample(1'b0, 1'b0);
        vectors++; if (state !== 2'd3) begin errors++; $display("FAIL rstp_refr got=%0d exp=3", state); end
        rst = 1'b1;
        rr_ready = 1'b1;
        step();
        rst = 1'b0;
        rr_ready = 1'b0;
        vectors++; if (state !== 2'd0) begin errors++; $display("FAIL rstp_state got=%0d exp=0", state); end
        vectors++; if (rr_valid !== 1'b0 || rr_data !== 12'd0) begin errors++; $display("FAIL rstp_rr got=%0b/%0d exp=0/0", rr_valid, rr_data); end
    endtask

`ifdef RR_AVG_EN
    task automatic test_avg();
        do_reset();
        make_beat(1'b0);
        for (int i = 0; i < 8; i++) gap_beat(80, 1'b1);
        vectors++; if (rr_avg !== 12'd80) begin errors++; $display("FAIL avg_80 got=%0d exp=80", rr_avg); end
        gap_beat(160, 1'b1);
        vectors++; if (rr_avg !== 12'd90) begin errors++; $display("FAIL avg_90 got=%0d exp=90", rr_avg); end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_refractory();
        test_rr_interval();
        test_overrun();
        test_back_to_back();
        test_en_drop();
        test_rst_priority();
`ifdef RR_AVG_EN
        test_avg();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
